dsp_addsub_arbiter: RTL and testbench

- Shares the single SB_MAC16-based 32-bit add/sub wrapper between two requesters, e.g. the ALU and the branch-target/address adder in sail-core.
- Arbitrates round-robin and latches the winner's operands.
- Sequences the combinational DSP adder for one pass (32-bit op) or two chained passes (64-bit op, carry/borrow propagated).
- Returns a registered result with a one-cycle response pulse.

---
 rtl/dsp_addsub_arbiter.sv | 110 +++++++++++
 tb/tb_dsp_addsub_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dsp_addsub_arbiter.sv
// dsp_addsub_arbiter: round-robin sharing of one 32-bit DSP add/sub between two requesters,
// one pass for 32-bit ops, two carry-chained passes for 64-bit ops, registered response.
module dsp_addsub_arbiter #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_sub,
    input  logic        req0_wide,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_sub,
    input  logic        req1_wide,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [63:0] rsp_result,
    output logic        rsp_carry,
    output logic        busy,
    output logic [31:0] dsp_in1,
    output logic [31:0] dsp_in2,
    output logic        dsp_sub,
    output logic        dsp_ci,
    input  logic [31:0] dsp_out,
    input  logic        dsp_co
);
    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;
    state_t state, state_next;
    logic ptr, id, sub, wide, c_lo, grant0, grant1, accept;
    logic [63:0] a, b;
    logic [31:0] res_lo;

    assign grant0 = req0_valid & (~req1_valid | ~ptr);
    assign grant1 = req1_valid & (~req0_valid | ptr);
    assign req0_ready = rst_n & (state == IDLE) & grant0;
    assign req1_ready = rst_n & (state == IDLE) & grant1;
    assign accept = req0_ready | req1_ready;
    assign busy = state != IDLE;

    always_comb begin
        state_next = state;
        dsp_in1 = '0;
        dsp_in2 = '0;
        dsp_sub = 1'b0;
        dsp_ci = 1'b0;
        case (state)
            IDLE: state_next = accept ? LO : IDLE;
            LO: begin
                dsp_in1 = a[31:0];
                dsp_in2 = b[31:0];
                dsp_sub = sub;
                state_next = wide ? HI : RESP;
            end
            HI: begin
                dsp_in1 = a[63:32];
                dsp_in2 = b[63:32];
                dsp_sub = sub;
                dsp_ci = c_lo;
                state_next = RESP;
            end
            default: state_next = IDLE;
        endcase
    end

    // The response is captured on the final pass so it holds until the next op completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr <= RR_INIT;
            id <= 1'b0;
            sub <= 1'b0;
            wide <= 1'b0;
            a <= '0;
            b <= '0;
            res_lo <= '0;
            c_lo <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_result <= '0;
            rsp_carry <= 1'b0;
        end else begin
            state <= state_next;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            if (accept) begin
                id <= req1_ready;
                ptr <= req0_ready;
                sub <= req1_ready ? req1_sub : req0_sub;
                wide <= req1_ready ? req1_wide : req0_wide;
                a <= req1_ready ? req1_a : req0_a;
                b <= req1_ready ? req1_b : req0_b;
            end
            if (state == LO) begin
                res_lo <= dsp_out;
                c_lo <= dsp_co;
            end
            if (state_next == RESP) begin
                rsp0_valid <= ~id;
                rsp1_valid <= id;
                rsp_result <= (state == HI) ? {dsp_out, res_lo} : {32'h0, dsp_out};
                rsp_carry <= dsp_co;
            end
        end
    end
endmodule

// File: tb/tb_dsp_addsub_arbiter.sv
// tb_dsp_addsub_arbiter: directed vector table plus contention and mid-op reset sequences,
// with a behavioural model of the 32-bit add/sub wrapper on the dsp_* side.
module tb_dsp_addsub_arbiter;
    logic clk = 1'b0, rst_n = 1'b0;
    logic req0_valid, req0_ready, req0_sub, req0_wide;
    logic req1_valid, req1_ready, req1_sub, req1_wide;
    logic [63:0] req0_a, req0_b, req1_a, req1_b, rsp_result;
    logic rsp0_valid, rsp1_valid, rsp_carry, busy, dsp_sub, dsp_ci, dsp_co;
    logic [31:0] dsp_in1, dsp_in2, dsp_out;
    logic [32:0] pass_sum;
    int checks = 0, failures = 0;

    typedef struct packed {
        bit who;
        bit sub;
        bit wide;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        bit carry;
        bit hi_ci;
    } vec_t;

    dsp_addsub_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sub(req0_sub),
        .req0_wide(req0_wide), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sub(req1_sub),
        .req1_wide(req1_wide), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .busy(busy),
        .dsp_in1(dsp_in1), .dsp_in2(dsp_in2), .dsp_sub(dsp_sub), .dsp_ci(dsp_ci),
        .dsp_out(dsp_out), .dsp_co(dsp_co)
    );

    always #5 clk = ~clk;

    assign pass_sum = dsp_sub ? {1'b0, dsp_in1} - {1'b0, dsp_in2} - {32'b0, dsp_ci}
                              : {1'b0, dsp_in1} + {1'b0, dsp_in2} + {32'b0, dsp_ci};
    assign dsp_out = pass_sum[31:0];
    assign dsp_co = pass_sum[32];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit who, input bit v, input bit s, input bit w,
                           input logic [63:0] x, input logic [63:0] y);
        if (who) begin
            req1_valid = v; req1_sub = s; req1_wide = w; req1_a = x; req1_b = y;
        end else begin
            req0_valid = v; req0_sub = s; req0_wide = w; req0_a = x; req0_b = y;
        end
    endtask

    task automatic run_op(input vec_t v, output int lat, output logic [63:0] res,
                          output logic carry, output logic hi_ci, output logic other);
        lat = 0;
        other = 1'b0;
        hi_ci = 1'b0;
        set_req(v.who, 1'b1, v.sub, v.wide, v.a, v.b);
        #1;
        check("ready", {63'b0, v.who ? req1_ready : req0_ready}, 64'd1);
        tick();
        set_req(v.who, 1'b0, ~v.sub, ~v.wide, ~v.a, ~v.b);
        lat = 1;
        while (lat < 8 && !(v.who ? rsp1_valid : rsp0_valid)) begin
            other |= v.who ? rsp0_valid : rsp1_valid;
            if (lat == 2) hi_ci = dsp_ci;
            tick();
            lat++;
        end
        res = rsp_result;
        carry = rsp_carry;
    endtask

    vec_t vecs[10];
    int lat;
    logic [63:0] res;
    logic carry, hi_ci, other, both_rsp, any_rsp;
    bit order[$];
    int when[$];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 64'hFFFFFFFF, 64'h1, 64'h0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 64'h5, 64'h7, 64'h00000000FFFFFFFE, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 64'h00000000FFFFFFFF, 64'h1, 64'h0000000100000000, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 64'h0000000100000000, 64'h1, 64'h00000000FFFFFFFF, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 64'h0, 64'h1, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 64'hDEADBEEF00000003, 64'h1234567800000004, 64'h7, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 64'h0000000180000000, 64'h0000000280000000, 64'h0000000400000000, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'h1, 64'h0, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 64'h9, 64'h9, 64'h0, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 1'b1, 1'b1, 64'h0000000200000003, 64'h0000000100000001, 64'h0000000100000002, 1'b0, 1'b0};
        set_req(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
        set_req(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        #2;
        check("reset ready0", {63'b0, req0_ready}, 64'd0);
        check("reset busy", {63'b0, busy}, 64'd0);
        check("reset rsp", {62'b0, rsp0_valid, rsp1_valid}, 64'd0);
        check("reset result", rsp_result, 64'd0);
        check("reset dsp", {dsp_in1, dsp_in2[29:0], dsp_sub, dsp_ci}, 64'd0);
        tick();
        tick();
        req0_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            run_op(vecs[i], lat, res, carry, hi_ci, other);
            check($sformatf("v%0d latency", i), 64'(lat), vecs[i].wide ? 64'd3 : 64'd2);
            check($sformatf("v%0d result", i), res, vecs[i].res);
            check($sformatf("v%0d carry", i), {63'b0, carry}, {63'b0, vecs[i].carry});
            check($sformatf("v%0d other rsp", i), {63'b0, other}, 64'd0);
            if (vecs[i].wide) check($sformatf("v%0d hi ci", i), {63'b0, hi_ci}, {63'b0, vecs[i].hi_ci});
            tick();
            check($sformatf("v%0d pulse end", i), {62'b0, rsp0_valid, rsp1_valid, busy}, 64'd0);
            check($sformatf("v%0d result hold", i), rsp_result, vecs[i].res);
        end

        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        set_req(1'b0, 1'b1, 1'b0, 1'b0, 64'd1, 64'd1);
        set_req(1'b1, 1'b1, 1'b0, 1'b0, 64'd2, 64'd2);
        #1;
        both_rsp = 1'b0;
        for (int c = 0; c < 12; c++) begin
            both_rsp |= rsp0_valid & rsp1_valid;
            if (req0_ready & req1_ready) both_rsp = 1'b1;
            if (req0_ready | req1_ready) begin
                order.push_back(req1_ready);
                when.push_back(c);
            end
            tick();
        end
        set_req(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        set_req(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        check("contention grants", 64'(order.size()), 64'd4);
        check("contention overlap", {63'b0, both_rsp}, 64'd0);
        for (int k = 0; k < order.size(); k++) begin
            check($sformatf("grant%0d id", k), {63'b0, order[k]}, 64'(k % 2));
            if (k > 0) check($sformatf("grant%0d spacing", k), 64'(when[k] - when[k-1]), 64'd3);
        end
        tick();
        tick();
        tick();

        set_req(1'b0, 1'b1, 1'b0, 1'b1, 64'h00000000FFFFFFFF, 64'h1);
        #1;
        check("midreset ready", {63'b0, req0_ready}, 64'd1);
        tick();
        set_req(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        tick();
        check("midreset in HI", {63'b0, dsp_ci & busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("midreset busy", {63'b0, busy}, 64'd0);
        check("midreset result", {rsp_result[62:0], rsp_carry}, 64'd0);
        any_rsp = 1'b0;
        for (int c = 0; c < 3; c++) begin
            any_rsp |= rsp0_valid | rsp1_valid;
            tick();
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            any_rsp |= rsp0_valid | rsp1_valid;
            tick();
        end
        check("midreset no rsp", {63'b0, any_rsp}, 64'd0);
        set_req(1'b0, 1'b1, 1'b0, 1'b0, 64'd2, 64'd3);
        set_req(1'b1, 1'b1, 1'b0, 1'b0, 64'd10, 64'd10);
        #1;
        check("ptr after reset", {62'b0, req0_ready, req1_ready}, 64'd2);
        tick();
        set_req(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        set_req(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        tick();
        check("post reset rsp0", {62'b0, rsp0_valid, rsp1_valid}, 64'd2);
        check("post reset result", rsp_result, 64'd5);
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
